// File: rtl/miner_nonce_scheduler.sv
// miner_nonce_scheduler: hands out a nonce range across miner cores round-robin and reports the first hit or exhaustion
module miner_nonce_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int NONCE_W = 32
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 job_start,
  input  logic                 job_abort,
  input  logic [NONCE_W-1:0]   nonce_base,
  input  logic [NONCE_W-1:0]   nonce_limit,
  input  logic [NUM_CORES-1:0] core_finished,
  input  logic [NUM_CORES-1:0] core_hit,
  output logic [NUM_CORES-1:0] core_start,
  output logic [NONCE_W-1:0]   core_nonce,
  output logic                 found,
  output logic [NONCE_W-1:0]   found_nonce,
  output logic                 exhausted,
  output logic                 busy
);
  localparam int PW = $clog2(NUM_CORES);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [NONCE_W-1:0] next_nonce, limit_q, found_nonce_q;
  logic [NONCE_W-1:0] nonce_q [NUM_CORES];
  logic [NUM_CORES-1:0] busy_map, busy_nxt, hits, start_vec;
  logic [PW-1:0] ptr, sel, cand, hit_idx;
  logic last_issued, found_q, exhausted_q, have_idle, issue, hit_any, idle_or_done, active;
  int idx;
  always_comb begin
    sel = '0;
    cand = '0;
    have_idle = 1'b0;
    hit_idx = '0;
    idx = 0;
    // Scan downwards so the candidate closest to ptr (and the lowest hit index) is kept last
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      idx = idx >= NUM_CORES ? idx - NUM_CORES : idx;
      cand = PW'(idx);
      if (!busy_map[cand]) begin
        sel = cand;
        have_idle = 1'b1;
      end
      if (hits[PW'(k)]) hit_idx = PW'(k);
    end
  end
  assign active       = state == RUN || state == DRAIN;
  assign idle_or_done = state == IDLE || state == DONE;
  assign issue        = state == RUN && !last_issued && have_idle;
  assign start_vec    = issue ? NUM_CORES'(1) << sel : '0;
  assign hits         = core_finished & core_hit & busy_map;
  assign hit_any      = |hits;
  assign busy_nxt     = (busy_map & ~core_finished) | start_vec;
  assign core_start   = start_vec;
  assign core_nonce   = issue ? next_nonce : '0;
  assign found        = found_q;
  assign found_nonce  = found_nonce_q;
  assign exhausted    = exhausted_q;
  assign busy         = active;
  always_comb begin
    state_n = (job_abort && state != IDLE) ? IDLE
            : (idle_or_done && job_start) ? RUN
            : (active && hit_any) ? DONE
            : (issue && next_nonce == limit_q) ? DRAIN
            : (state == DRAIN && busy_nxt == '0) ? DONE
            : state;
  end
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= IDLE;
      next_nonce <= '0;
      limit_q <= '0;
      ptr <= '0;
      busy_map <= '0;
      last_issued <= 1'b0;
      found_q <= 1'b0;
      exhausted_q <= 1'b0;
      found_nonce_q <= '0;
    end else begin
      state <= state_n;
      if (job_abort && state != IDLE) begin
        busy_map <= '0;
        last_issued <= 1'b0;
        found_q <= 1'b0;
        exhausted_q <= 1'b0;
        found_nonce_q <= '0;
      end else if (idle_or_done && job_start) begin
        next_nonce <= nonce_base;
        limit_q <= nonce_limit;
        ptr <= '0;
        busy_map <= '0;
        last_issued <= 1'b0;
        found_q <= 1'b0;
        exhausted_q <= 1'b0;
        found_nonce_q <= '0;
      end else if (active) begin
        busy_map <= busy_nxt;
        if (issue) begin
          nonce_q[sel] <= next_nonce;
          next_nonce <= next_nonce + 1'b1;
          ptr <= sel == PW'(NUM_CORES - 1) ? '0 : sel + 1'b1;
          if (next_nonce == limit_q) last_issued <= 1'b1;
        end
        if (hit_any) begin
          found_q <= 1'b1;
          found_nonce_q <= nonce_q[hit_idx];
        end else if (state_n == DONE) begin
          exhausted_q <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_miner_nonce_scheduler.sv
// tb_miner_nonce_scheduler: vector table, directed corner sequences and a random run against a reference model
module tb_miner_nonce_scheduler;
  localparam int N = 4;
  logic clk = 0, n_rst = 0, job_start = 0, job_abort = 0;
  logic [31:0] nonce_base = 0, nonce_limit = 0;
  logic [N-1:0] core_finished = 0, core_hit = 0, core_start;
  logic [31:0] core_nonce, found_nonce;
  logic found, exhausted, busy;
  int checks = 0, errors = 0;
  typedef struct {
    bit js;
    logic [3:0] fin, hit;
    logic [31:0] base, limit;
    logic [3:0] s;
    logic [31:0] n;
    bit f;
    logic [31:0] fn;
    bit e, b;
  } vec_t;
  vec_t tbl[15];
  int m_phase, m_ptr;
  logic [31:0] m_next, m_limit, m_fn;
  logic [31:0] m_nv[N];
  bit m_last, m_found, m_exh;
  bit m_busy[N];
  miner_nonce_scheduler #(.NUM_CORES(N), .NONCE_W(32)) dut (
    .clk(clk), .n_rst(n_rst), .job_start(job_start), .job_abort(job_abort),
    .nonce_base(nonce_base), .nonce_limit(nonce_limit),
    .core_finished(core_finished), .core_hit(core_hit),
    .core_start(core_start), .core_nonce(core_nonce), .found(found),
    .found_nonce(found_nonce), .exhausted(exhausted), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic expect_out(input string tag, input logic [3:0] s, input logic [31:0] n, input logic f,
                            input logic [31:0] fn, input logic e, input logic b);
    chk({tag, ".start"}, 32'(core_start), 32'(s));
    chk({tag, ".nonce"}, core_nonce, n);
    chk({tag, ".found"}, 32'(found), 32'(f));
    chk({tag, ".found_nonce"}, found_nonce, fn);
    chk({tag, ".exhausted"}, 32'(exhausted), 32'(e));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
  endtask
  task automatic cyc(input logic js, input logic ja, input logic [3:0] fin, input logic [3:0] hit,
                     input logic [31:0] b, input logic [31:0] l);
    job_start = js; job_abort = ja; core_finished = fin; core_hit = hit;
    nonce_base = b; nonce_limit = l;
    @(posedge clk); #1;
    job_start = 0; job_abort = 0; core_finished = 0; core_hit = 0;
  endtask
  initial begin
    for (int i = 0; i < 15; i++) tbl[i] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    tbl[0] = '{1, 0, 0, 32'h100, 32'h1FF, 4'h1, 32'h100, 0, 0, 0, 1};
    tbl[1].s = 4'h2; tbl[1].n = 32'h101;
    tbl[2].s = 4'h4; tbl[2].n = 32'h102;
    tbl[3].s = 4'h8; tbl[3].n = 32'h103;
    tbl[10].fin = 4'h4; tbl[10].s = 4'h4; tbl[10].n = 32'h104;
    tbl[12].fin = 4'hA; tbl[12].hit = 4'hA;
    tbl[13].fin = 4'h1; tbl[13].hit = 4'h1;
    for (int i = 12; i < 15; i++) begin tbl[i].f = 1; tbl[i].fn = 32'h101; tbl[i].b = 0; end
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    expect_out("reset", 0, 0, 0, 0, 0, 0);
    n_rst = 1;
    // Fill, refill on core 2, then simultaneous hits on cores 1 and 3
    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].js, 0, tbl[i].fin, tbl[i].hit, tbl[i].base, tbl[i].limit);
      expect_out($sformatf("vec%0d", i), tbl[i].s, tbl[i].n, tbl[i].f, tbl[i].fn, tbl[i].e, tbl[i].b);
    end
    cyc(1, 0, 0, 0, 32'hFFFFFFFE, 32'h1);
    expect_out("wrap0", 4'h1, 32'hFFFFFFFE, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0); expect_out("wrap1", 4'h2, 32'hFFFFFFFF, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0); expect_out("wrap2", 4'h4, 32'h0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0); expect_out("wrap3", 4'h8, 32'h1, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0); expect_out("drain", 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 4'h7, 0, 0, 0); expect_out("drain_part", 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 4'h8, 0, 0, 0); expect_out("exhaust", 0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0); expect_out("exhaust_hold", 0, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 32'h500, 32'h5FF); expect_out("ab_start", 4'h1, 32'h500, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0); expect_out("ab_run", 4'h2, 32'h501, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0); expect_out("abort", 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 4'h3, 4'h3, 0, 0); expect_out("abort_ign", 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 32'h700, 32'h7FF); expect_out("ab_restart", 4'h1, 32'h700, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0); expect_out("abort2", 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 32'h10, 32'h11); expect_out("rs_start", 4'h1, 32'h10, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0); expect_out("rs_last", 4'h2, 32'h11, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0); expect_out("rs_drain", 0, 0, 0, 0, 0, 1);
    n_rst = 0;
    cyc(0, 0, 0, 0, 0, 0); expect_out("rs_reset", 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 32'h20, 32'h30); expect_out("rs_js_in_reset", 0, 0, 0, 0, 0, 0);
    n_rst = 1;
    cyc(0, 0, 0, 0, 0, 0); expect_out("rs_idle", 0, 0, 0, 0, 0, 0);
    m_phase = 0; m_ptr = 0; m_next = 0; m_limit = 0; m_fn = 0;
    m_last = 0; m_found = 0; m_exh = 0;
    for (int i = 0; i < N; i++) begin m_busy[i] = 0; m_nv[i] = 0; end
    for (int c = 0; c < 3000; c++) begin
      int esel, win, old;
      bit any, rb, js, ja;
      logic [3:0] fin, hit;
      logic [31:0] b, l;
      esel = -1;
      if (m_phase == 1 && !m_last)
        for (int k = 0; k < N; k++)
          if (esel < 0 && !m_busy[(m_ptr + k) % N]) esel = (m_ptr + k) % N;
      chk("rnd.start", 32'(core_start), esel >= 0 ? 32'(1) << esel : 32'h0);
      chk("rnd.nonce", core_nonce, esel >= 0 ? m_next : 32'h0);
      chk("rnd.found", 32'(found), 32'(m_found));
      chk("rnd.found_nonce", found_nonce, m_fn);
      chk("rnd.exhausted", 32'(exhausted), 32'(m_exh));
      chk("rnd.busy", 32'(busy), 32'(m_phase == 1 || m_phase == 2));
      rb = ($urandom % 400) != 0;
      js = ($urandom % 12) == 0;
      ja = ($urandom % 80) == 0;
      fin = ($urandom % 3 == 0) ? 4'($urandom) : 4'h0;
      hit = ($urandom % 6 == 0) ? fin & 4'($urandom) : 4'h0;
      b = ($urandom % 4 == 0) ? 32'hFFFFFFFF - ($urandom % 4) : $urandom;
      l = b + ($urandom % 10);
      if (!rb) begin
        m_phase = 0; m_found = 0; m_exh = 0; m_fn = 0; m_last = 0; m_ptr = 0; m_next = 0;
        for (int i = 0; i < N; i++) m_busy[i] = 0;
      end else if (ja && m_phase != 0) begin
        m_phase = 0; m_found = 0; m_exh = 0; m_fn = 0;
      end else if ((m_phase == 0 || m_phase == 3) && js) begin
        m_phase = 1; m_next = b; m_limit = l; m_ptr = 0; m_last = 0;
        m_found = 0; m_exh = 0; m_fn = 0;
        for (int i = 0; i < N; i++) m_busy[i] = 0;
      end else if (m_phase == 1 || m_phase == 2) begin
        old = m_phase;
        win = -1;
        for (int i = 0; i < N; i++) if (win < 0 && fin[i] && hit[i] && m_busy[i]) win = i;
        for (int i = 0; i < N; i++) if (fin[i]) m_busy[i] = 0;
        if (esel >= 0) begin
          m_busy[esel] = 1;
          m_nv[esel] = m_next;
          if (m_next == m_limit) begin m_last = 1; m_phase = 2; end
          m_next = m_next + 1;
          m_ptr = (esel + 1) % N;
        end
        any = 0;
        for (int i = 0; i < N; i++) any |= m_busy[i];
        if (win >= 0) begin m_phase = 3; m_found = 1; m_fn = m_nv[win]; end
        else if (old == 2 && !any) begin m_phase = 3; m_exh = 1; end
      end
      n_rst = rb;
      cyc(js, ja, fin, hit, b, l);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
